// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - PS2 keyboard command sequencer (init handshake, lock LEDs, scan-code forwarding)
//
// Sits between the PS2 host rx/tx datapath and the scan-code translator.
// Runs the 0xFF/ACK/BAT init handshake and tracks the Caps/Num/Scroll lock keys.
// Whenever a lock state changes it sends Set-LEDs (0xED + LED byte), with resend,
// timeout and bounded retry. Bytes that are not protocol replies are forwarded.
//
// Build option: PS2_KBD_INIT_EN
//   defined   - the init handshake runs after reset
//   undefined - reset goes straight to IDLE and 0xAA/0xFC are forwarded
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   rx_valid, rx_data      received byte strobe and value
//   tx_valid, tx_data      byte request to the transmitter
//   tx_ready               transmitter accepts on tx_valid & tx_ready
//   tx_done, tx_err        transmit complete / transmit failed pulses
//   fwd_valid, fwd_data    forwarded scan-code strobe and value
//   leds                   {caps, num, scroll} lock state
//   init_done              init handshake complete
//   busy                   command exchange in progress
//   ctrl_err               sticky failure flag

module ps2_kbd_ctrl #(
    parameter int ACK_TIMEOUT = 1000000,
    parameter int BAT_TIMEOUT = 50000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    input  logic       tx_done,
    input  logic       tx_err,
    output logic       fwd_valid,
    output logic [7:0] fwd_data,
    output logic [2:0] leds,
    output logic       init_done,
    output logic       busy,
    output logic       ctrl_err
);

    // One timer serves both the ACK and the BAT windows, so size it for the larger.
    localparam int TMAX = (BAT_TIMEOUT > ACK_TIMEOUT) ? BAT_TIMEOUT : ACK_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = $clog2(MAX_RETRY + 1);

    localparam logic [TW-1:0] ACK_LIM   = TW'(ACK_TIMEOUT);
    localparam logic [TW-1:0] TIMER_SAT = {TW{1'b1}};
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
`ifdef PS2_KBD_INIT_EN
    localparam logic [TW-1:0] BAT_LIM   = TW'(BAT_TIMEOUT);
`endif

    localparam logic [7:0] B_RESET = 8'hFF;
    localparam logic [7:0] B_SETLED = 8'hED;
    localparam logic [7:0] B_ACK   = 8'hFA;
    localparam logic [7:0] B_RESEND = 8'hFE;
    localparam logic [7:0] B_BAT_OK = 8'hAA;
    localparam logic [7:0] B_BAT_ERR = 8'hFC;
    localparam logic [7:0] B_BREAK = 8'hF0;
    localparam logic [7:0] B_EXT   = 8'hE0;
    localparam logic [7:0] K_CAPS  = 8'h58;
    localparam logic [7:0] K_NUM   = 8'h77;
    localparam logic [7:0] K_SCROLL = 8'h7E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_TX,
        ST_WAIT_ACK,
        ST_BAT_WAIT,
        ST_ERROR
    } state_t;

    // Which byte the shared send sub-sequence is carrying.
    typedef enum logic [1:0] {
        PH_INIT,
        PH_LED_CMD,
        PH_LED_VAL
    } phase_t;

`ifdef PS2_KBD_INIT_EN
    localparam state_t RESET_STATE = ST_SEND;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t          state, state_next;
    phase_t          phase, phase_next;
    logic [RW-1:0]   retry, retry_next;
    logic [TW-1:0]   timer, timer_next;
    logic [2:0]      led_snap, snap_next;
    logic            brk;
    logic            dirty;
    logic            dirty_clr;
    logic            fail;
    logic            do_retry;
    logic [7:0]      byte_next;

    logic            rx_consumed;
    logic            rx_fwd;
    logic            lock_key;
    logic            lock_hit;

    // Protocol replies are swallowed only where the sequencer is waiting for them.
    always_comb begin
        rx_consumed = 1'b0;
        if (rx_valid && state == ST_WAIT_ACK && (rx_data == B_ACK || rx_data == B_RESEND))
            rx_consumed = 1'b1;
`ifdef PS2_KBD_INIT_EN
        if (rx_valid && state == ST_BAT_WAIT && (rx_data == B_BAT_OK || rx_data == B_BAT_ERR))
            rx_consumed = 1'b1;
`endif
    end

    assign rx_fwd   = rx_valid && !rx_consumed;
    assign lock_key = (rx_data == K_CAPS) || (rx_data == K_NUM) || (rx_data == K_SCROLL);
    assign lock_hit = rx_fwd && !brk && lock_key;

    always_comb begin
        state_next = state;
        phase_next = phase;
        retry_next = retry;
        snap_next  = led_snap;
        dirty_clr  = 1'b0;
        fail       = 1'b0;
        do_retry   = 1'b0;
        timer_next = (timer != TIMER_SAT) ? timer + 1'b1 : timer;

        case (state)
            ST_IDLE: begin
                timer_next = '0;
                if (dirty) begin
                    dirty_clr  = 1'b1;
                    snap_next  = leds;
                    phase_next = PH_LED_CMD;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                // Held at zero so the ACK window starts at the accepting edge.
                timer_next = '0;
                if (tx_valid && tx_ready)
                    state_next = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_err || timer == ACK_LIM) begin
                    do_retry = 1'b1;
                end else if (tx_done) begin
                    timer_next = '0;
                    state_next = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // A received byte is examined before the timeout so it wins a tie.
                if (rx_valid && rx_data == B_ACK) begin
                    retry_next = '0;
                    timer_next = '0;
                    case (phase)
                        PH_INIT:    state_next = ST_BAT_WAIT;
                        PH_LED_CMD: begin
                            phase_next = PH_LED_VAL;
                            state_next = ST_SEND;
                        end
                        default:    state_next = ST_IDLE;
                    endcase
                end else if ((rx_valid && rx_data == B_RESEND) || tx_err || timer == ACK_LIM) begin
                    do_retry = 1'b1;
                end
            end
            ST_BAT_WAIT: begin
`ifdef PS2_KBD_INIT_EN
                if (rx_valid && rx_data == B_BAT_OK)
                    state_next = ST_IDLE;
                else if ((rx_valid && rx_data == B_BAT_ERR) || timer == BAT_LIM)
                    state_next = ST_ERROR;
`else
                state_next = ST_IDLE;
`endif
            end
            ST_ERROR: begin
                timer_next = '0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (do_retry) begin
            if (retry < RETRY_MAX) begin
                retry_next = retry + 1'b1;
                state_next = ST_SEND;
            end else begin
                // Out of retries: init is fatal, an LED update is just abandoned.
                retry_next = '0;
                fail       = 1'b1;
                state_next = (phase == PH_INIT) ? ST_ERROR : ST_IDLE;
            end
        end
    end

    always_comb begin
        case (phase_next)
            PH_INIT:    byte_next = B_RESET;
            PH_LED_CMD: byte_next = B_SETLED;
            default:    byte_next = {5'b0, snap_next};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RESET_STATE;
            phase     <= PH_INIT;
            retry     <= '0;
            timer     <= '0;
            led_snap  <= '0;
            brk       <= 1'b0;
            dirty     <= 1'b0;
            leds      <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            fwd_valid <= 1'b0;
            fwd_data  <= '0;
            init_done <= 1'b0;
            busy      <= 1'b0;
            ctrl_err  <= 1'b0;
        end else begin
            state    <= state_next;
            phase    <= phase_next;
            retry    <= retry_next;
            timer    <= timer_next;
            led_snap <= snap_next;

            // Registered from the next state so tx_valid is low through reset.
            tx_valid <= (state_next == ST_SEND);
            tx_data  <= byte_next;
            busy     <= (state_next != ST_IDLE) && (state_next != ST_ERROR);
            ctrl_err <= ctrl_err || fail || (state_next == ST_ERROR);

`ifdef PS2_KBD_INIT_EN
            if (state_next == ST_ERROR)
                init_done <= 1'b0;
            else if (state == ST_BAT_WAIT && state_next == ST_IDLE)
                init_done <= 1'b1;
`else
            init_done <= 1'b1;
`endif

            fwd_valid <= rx_fwd;
            if (rx_fwd)
                fwd_data <= rx_data;

            if (rx_fwd) begin
                if (rx_data == B_BREAK) begin
                    brk <= 1'b1;
                end else if (rx_data != B_EXT) begin
                    brk <= 1'b0;
                    if (!brk) begin
                        if (rx_data == K_CAPS)   leds[2] <= ~leds[2];
                        if (rx_data == K_NUM)    leds[1] <= ~leds[1];
                        if (rx_data == K_SCROLL) leds[0] <= ~leds[0];
                    end
                end
            end

            // A new toggle outranks the snapshot clear so no change is lost.
            if (lock_hit)
                dirty <= 1'b1;
            else if (dirty_clr)
                dirty <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb/tb_ps2_kbd_ctrl.sv - scoreboard bench for ps2_kbd_ctrl
module tb_ps2_kbd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b1;
    logic       tx_done = 1'b0;
    logic       tx_err = 1'b0;
    logic       fwd_valid;
    logic [7:0] fwd_data;
    logic [2:0] leds;
    logic       init_done;
    logic       busy;
    logic       ctrl_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_tx[$];
    logic [7:0] exp_fwd[$];

    ps2_kbd_ctrl #(
        .ACK_TIMEOUT(100),
        .BAT_TIMEOUT(2000),
        .MAX_RETRY(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .tx_done(tx_done),
        .tx_err(tx_err),
        .fwd_valid(fwd_valid),
        .fwd_data(fwd_data),
        .leds(leds),
        .init_done(init_done),
        .busy(busy),
        .ctrl_err(ctrl_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Every offered byte is taken (tx_ready held high), so a high tx_valid at a
    // falling edge is exactly one transmitted byte.
    always @(negedge clk) begin
        if (tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) check("tx_unexpected", 32'(tx_data), 32'h100);
            else check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (fwd_valid) begin
            if (exp_fwd.size() == 0) check("fwd_unexpected", 32'(fwd_data), 32'h100);
            else check("fwd_data", 32'(fwd_data), 32'(exp_fwd.pop_front()));
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx();
        int n = 0;
        while (!tx_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!tx_valid) check("tx_wait_timeout", 32'(tx_valid), 32'h1);
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // Byte accepted, line-level completion, then the device reply (if any).
    task automatic exchange(input logic [7:0] resp, input bit give_resp);
        wait_tx();
        @(negedge clk);
        pulse_done();
        if (give_resp) send_rx(resp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef PS2_KBD_INIT_EN
    task automatic run_init();
        exp_tx.push_back(8'hFF);
        exchange(8'hFA, 1'b1);
        cycles(2);
        send_rx(8'hAA);
        @(negedge clk);
        check("init_done", 32'(init_done), 32'h1);
        check("init_busy", 32'(busy), 32'h0);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        cycles(3);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_init_done", 32'(init_done), 32'h0);
        check("rst_leds", 32'(leds), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ctrl_err", 32'(ctrl_err), 32'h0);
        check("rst_fwd_valid", 32'(fwd_valid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef PS2_KBD_INIT_EN
        // BAT failure, then recovery through reset
        exp_tx.push_back(8'hFF);
        exchange(8'hFA, 1'b1);
        cycles(2);
        send_rx(8'hFC);
        @(negedge clk);
        check("bat_ctrl_err", 32'(ctrl_err), 32'h1);
        check("bat_init_done", 32'(init_done), 32'h0);
        check("bat_busy", 32'(busy), 32'h0);
        do_reset();
        check("recover_ctrl_err", 32'(ctrl_err), 32'h0);
        run_init();
`else
        check("init_done_noinit", 32'(init_done), 32'h1);
        check("busy_noinit", 32'(busy), 32'h0);
`endif

        // Caps on, with Num pressed during the exchange
        exp_fwd.push_back(8'h58);
        exp_tx.push_back(8'hED);
        exp_tx.push_back(8'h04);
        send_rx(8'h58);
        check("caps_leds", 32'(leds), 32'h4);
        wait_tx();
        exp_fwd.push_back(8'h77);
        exp_tx.push_back(8'hED);
        exp_tx.push_back(8'h06);
        send_rx(8'h77);
        check("overlap_leds", 32'(leds), 32'h6);
        pulse_done();
        send_rx(8'hFA);
        exchange(8'hFA, 1'b1);
        exchange(8'hFA, 1'b1);
        exchange(8'hFA, 1'b1);
        cycles(2);
        check("overlap_busy", 32'(busy), 32'h0);
        check("overlap_ctrl_err", 32'(ctrl_err), 32'h0);

        // Break code: no toggle, nothing sent
        exp_fwd.push_back(8'hF0);
        exp_fwd.push_back(8'h58);
        send_rx(8'hF0);
        send_rx(8'h58);
        cycles(3);
        check("break_leds", 32'(leds), 32'h6);
        check("break_busy", 32'(busy), 32'h0);

        // Resend: first 0xED answered 0xFE
        exp_fwd.push_back(8'h7E);
        exp_tx.push_back(8'hED);
        exp_tx.push_back(8'hED);
        exp_tx.push_back(8'h07);
        send_rx(8'h7E);
        exchange(8'hFE, 1'b1);
        exchange(8'hFA, 1'b1);
        exchange(8'hFA, 1'b1);
        cycles(2);
        check("resend_leds", 32'(leds), 32'h7);
        check("resend_ctrl_err", 32'(ctrl_err), 32'h0);
        check("resend_busy", 32'(busy), 32'h0);

        // Timeout: four unanswered 0xED, LED byte never sent
        exp_fwd.push_back(8'h7E);
        for (int i = 0; i < 4; i++) exp_tx.push_back(8'hED);
        send_rx(8'h7E);
        for (int i = 0; i < 4; i++) exchange(8'h00, 1'b0);
        cycles(150);
        check("timeout_ctrl_err", 32'(ctrl_err), 32'h1);
        check("timeout_busy", 32'(busy), 32'h0);
        check("timeout_leds", 32'(leds), 32'h6);
        check("timeout_tx_left", 32'(exp_tx.size()), 32'h0);

        // tx_done while idle is ignored; 0xAA/0xFC outside BAT_WAIT are forwarded
        pulse_done();
        cycles(2);
        check("stray_done_busy", 32'(busy), 32'h0);
        exp_fwd.push_back(8'hAA);
        exp_fwd.push_back(8'hFC);
        send_rx(8'hAA);
        send_rx(8'hFC);
        cycles(2);
        check("fwd_left", 32'(exp_fwd.size()), 32'h0);

        // Reset in the middle of an exchange
        exp_fwd.push_back(8'h58);
        exp_tx.push_back(8'hED);
        send_rx(8'h58);
        wait_tx();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_tx_valid", 32'(tx_valid), 32'h0);
        check("midrst_leds", 32'(leds), 32'h0);
        check("midrst_ctrl_err", 32'(ctrl_err), 32'h0);
        cycles(2);
        rst_n = 1'b1;
        @(negedge clk);
`ifdef PS2_KBD_INIT_EN
        run_init();
`else
        check("midrst_init_done", 32'(init_done), 32'h1);
`endif
        cycles(3);
        check("end_tx_left", 32'(exp_tx.size()), 32'h0);
        check("end_fwd_left", 32'(exp_fwd.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
Command sequencer between the PS2 host receive/transmit datapath and the scan-code consumers.
- After reset, runs the keyboard init handshake: send 0xFF, expect ACK 0xFA, then BAT 0xAA.
- Tracks Caps/Num/Scroll lock from received make codes and, on each change, sends Set-LEDs (0xED + LED byte), handling ACK, resend (0xFE), timeout and retry.
- Forwards all non-protocol bytes to the downstream scan-code translator.

Parameters:
ACK_TIMEOUT, 1000000, max cycles from tx_done to ACK (or from tx accept to tx_done) before a retry.
BAT_TIMEOUT, 50000000, max cycles from ACK of 0xFF to BAT result.
MAX_RETRY, 3, resend attempts per byte before failure; counter width $clog2(MAX_RETRY+1).

Ports:
clk  in  1  system clock
rst_n  in  1  reset (synchronous, active-low)
rx_valid  in  1  one-cycle pulse: received byte from the PS2 host
rx_data  in  8  received byte
tx_valid  out  1  request to send tx_data
tx_data  out  8  byte to send
tx_ready  in  1  transmitter accepts when tx_valid&tx_ready
tx_done  in  1  pulse: byte fully sent, device line-ACK seen
tx_err  in  1  pulse: transmit failed
fwd_valid  out  1  forwarded scan-code strobe
fwd_data  out  8  forwarded scan code
leds  out  3  {caps,num,scroll} lock state
init_done  out  1  init handshake complete
busy  out  1  command exchange in progress (state != IDLE/ERROR)
ctrl_err  out  1  sticky failure flag

Behaviour:
- Reset: all outputs 0; state=INIT_SEND; retry=0; timer=0; brk=0; dirty=0.
- Send sub-sequence, per byte: SEND (tx_valid=1, tx_data stable until tx_ready) -> WAIT_TX (until tx_done) -> WAIT_ACK.
  - ACK timer starts at tx accept and restarts at tx_done.
  - In WAIT_ACK: 0xFA = success; 0xFE, tx_err, or timer==ACK_TIMEOUT = retry.
- Retry: retry<MAX_RETRY -> retry++, back to SEND with the same byte. Otherwise failure. retry clears on each byte success.
- Init sequence: INIT_SEND(0xFF) -> ... -> BAT_WAIT.
  - 0xAA: init_done=1 next cycle, go to IDLE.
  - 0xFC, or BAT_TIMEOUT reached: ERROR.
  - Any init failure also goes to ERROR.
- ERROR: ctrl_err=1, init_done=0, terminal until rst_n.
- LED sequence: IDLE with dirty=1 -> snapshot leds and clear dirty in the same cycle.
  - Send 0xED, then the LED byte {5'b0,caps,num,scroll}, then IDLE.
  - Failure: ctrl_err=1, abandon the update, return to IDLE (not ERROR).
- Consumed bytes (never forwarded): 0xFA/0xFE while in WAIT_ACK; 0xAA/0xFC while in BAT_WAIT.
- All other rx bytes are forwarded: fwd_valid/fwd_data registered, 1-cycle latency.
- Lock tracking, forwarded bytes only:
  - 0xF0 sets brk. 0xE0 leaves brk unchanged.
  - Any other byte clears brk; if brk was 0, 0x58 toggles caps, 0x77 toggles num, 0x7E toggles scroll, and dirty is set.
  - leds update the cycle after the byte.
- Toggle during an LED sequence: dirty is set again, so a second sequence runs after return to IDLE.
- Toggle before init_done: leds update and dirty is set; the sequence runs on entry to IDLE.
- Simultaneous rx_valid and timer expiry in WAIT_ACK: the rx byte wins.
- tx_done outside WAIT_TX: ignored.
- rst_n low mid-exchange: tx_valid drops next edge; the full init sequence restarts.

Optional Feature:
PS2_KBD_INIT_EN
- Defined: init sequence runs as above.
- Undefined: reset goes straight to IDLE; init_done=1 the first cycle after rst_n deasserts; BAT_TIMEOUT unused; 0xAA/0xFC are forwarded.

Test Plan:
- Init: device acks 0xFF with 0xFA, then 0xAA -> tx_data=0xFF sent once; init_done=1; no fwd_valid for 0xFA/0xAA.
- Caps: rx 0x58, then 0xF0,0x58 -> leds=3'b100; tx sequence 0xED, 0x04, each acked; second 0x58 (break) causes no toggle.
- Resend: first 0xED answered 0xFE, then 0xFA -> 0xED sent twice, then LED byte; ctrl_err=0.
- Timeout: no ACK after 0xED for 4 attempts (MAX_RETRY=3, ACK_TIMEOUT=100) -> ctrl_err=1, IDLE, busy=0, no LED byte sent.
- BAT failure: rx 0xFC during BAT_WAIT -> ERROR, ctrl_err=1, init_done=0; reset recovers.
- Overlap: 0x77 received during the Caps LED exchange -> after completion a second 0xED, 0x06 sequence runs; 0x77 forwarded.
